// File: rtl/tenkey_debounce.sv
// Ten-key keypad front end: two-flop synchronizer, debounce FSM and
// registered one-cycle accepted-key / multi-key pulses.
module tenkey_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] sw_raw,
    output logic [9:0] tenkey,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       multi_err
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    localparam logic [3:0] DB = 4'(DB_CYCLES);

    state_t     state, state_n;
    logic [9:0] sync1, sync;
    logic [9:0] samp, samp_n;
    logic [3:0] cnt, cnt_n, cnt_inc;
    logic [9:0] tenkey_n;
    logic       key_valid_n;
    logic [3:0] key_code_n;
    logic       multi_err_n;
    logic       samp_onehot;

    function automatic logic [3:0] encode(input logic [9:0] v);
        logic [3:0] idx;
        idx = 4'hF;
        for (int unsigned i = 0; i < 10; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync  <= '0;
        end else begin
            sync1 <= sw_raw;
            sync  <= sync1;
        end
    end

    // Counter saturates so a long-held pattern can never wrap back below DB.
    assign cnt_inc     = (cnt == 4'hF) ? cnt : cnt + 4'd1;
    assign samp_onehot = (samp != '0) && ((samp & (samp - 10'd1)) == '0);

    always_comb begin
        state_n     = state;
        samp_n      = samp;
        cnt_n       = cnt;
        tenkey_n    = '0;
        key_valid_n = 1'b0;
        key_code_n  = 4'hF;
        multi_err_n = 1'b0;
        case (state)
            IDLE: begin
                if (sync != '0) begin
                    samp_n  = sync;
                    cnt_n   = 4'd1;
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sync == '0) begin
                    state_n = IDLE;
                end else if (sync != samp) begin
                    samp_n = sync;
                    cnt_n  = 4'd1;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc >= DB) begin
                        if (samp_onehot) begin
                            tenkey_n    = samp;
                            key_valid_n = 1'b1;
                            key_code_n  = encode(samp);
                        end else begin
                            multi_err_n = 1'b1;
                        end
                        state_n = HELD;
                    end
                end
            end
            HELD: begin
                if (sync == '0) begin
                    cnt_n   = 4'd1;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (sync != '0) begin
                    state_n = HELD;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc >= DB) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            samp      <= '0;
            cnt       <= '0;
            tenkey    <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'hF;
            multi_err <= 1'b0;
        end else begin
            state     <= state_n;
            samp      <= samp_n;
            cnt       <= cnt_n;
            tenkey    <= tenkey_n;
            key_valid <= key_valid_n;
            key_code  <= key_code_n;
            multi_err <= multi_err_n;
        end
    end

endmodule

// File: tb/tb_tenkey_debounce.sv
// Directed bench for tenkey_debounce (DB_CYCLES=4): pulse timing, bounce,
// multi-key, release bounce and reset interaction.
module tb_tenkey_debounce;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] sw_raw = '0;
    logic [9:0] tenkey;
    logic       key_valid;
    logic [3:0] key_code;
    logic       multi_err;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    int         pulses = 0, merrs = 0, bad = 0;
    int         last_pcyc = -1, last_mcyc = -1;
    logic [9:0] last_key = '0, last_mkey = '0;
    logic [3:0] last_code = '0, last_mcode = '0;
    logic       last_valid = 1'b0;

    tenkey_debounce #(.DB_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .tenkey   (tenkey),
        .key_valid(key_valid),
        .key_code (key_code),
        .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    // cyc holds the number of the most recent rising edge
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tenkey != '0) begin
            pulses++;
            last_key   = tenkey;
            last_code  = key_code;
            last_valid = key_valid;
            last_pcyc  = cyc;
        end
        if (multi_err) begin
            merrs++;
            last_mkey  = tenkey;
            last_mcode = key_code;
            last_mcyc  = cyc;
        end
        if (key_valid !== (tenkey != '0)) bad++;
        if (!key_valid && key_code !== 4'hF) bad++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (tenkey !== 10'h000) begin errors++; $display("FAIL reset_tenkey got %h want 000", tenkey); end
        vectors++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
        vectors++;
        if (key_code !== 4'hF) begin errors++; $display("FAIL reset_code got %h want f", key_code); end
        vectors++;
        if (multi_err !== 1'b0) begin errors++; $display("FAIL reset_merr got %b want 0", multi_err); end
        sw_raw = 10'h3FF;
        tick(4);
        vectors++;
        if (pulses != 0 || merrs != 0) begin errors++; $display("FAIL reset_hold pulses %0d merrs %0d want 0 0", pulses, merrs); end
        sw_raw = '0;
        tick(1);
        reset = 1'b0;
        tick(6);
    endtask

    task automatic test_single_press;
        int p0, c;
        p0 = pulses;
        sw_raw = 10'h008;
        c = cyc;
        tick(12);
        vectors++;
        if (pulses - p0 != 1) begin errors++; $display("FAIL single_count got %0d want 1", pulses - p0); end
        vectors++;
        if (last_key !== 10'h008) begin errors++; $display("FAIL single_key got %h want 008", last_key); end
        vectors++;
        if (last_code !== 4'h3) begin errors++; $display("FAIL single_code got %h want 3", last_code); end
        vectors++;
        if (last_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", last_valid); end
        vectors++;
        if (last_pcyc != c + 6) begin errors++; $display("FAIL single_latency got edge %0d want %0d", last_pcyc, c + 6); end
        tick(8);
        vectors++;
        if (pulses - p0 != 1) begin errors++; $display("FAIL single_held got %0d want 1", pulses - p0); end
        sw_raw = '0;
        tick(10);
    endtask

    task automatic test_held_changes;
        int p0;
        p0 = pulses;
        sw_raw = 10'h002;
        tick(10);
        sw_raw = 10'h012;
        tick(4);
        sw_raw = 10'h010;
        tick(8);
        vectors++;
        if (pulses - p0 != 1 || last_code !== 4'h1) begin
            errors++;
            $display("FAIL held_changes got count %0d code %h want 1 1", pulses - p0, last_code);
        end
        sw_raw = '0;
        tick(10);
    endtask

    task automatic test_bounce;
        int p0, c;
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            sw_raw = (i % 2 == 0) ? 10'h080 : 10'h000;
            tick(1);
        end
        sw_raw = 10'h080;
        c = cyc;
        tick(14);
        vectors++;
        if (pulses - p0 != 1) begin errors++; $display("FAIL bounce_count got %0d want 1", pulses - p0); end
        vectors++;
        if (last_code !== 4'h7) begin errors++; $display("FAIL bounce_code got %h want 7", last_code); end
        vectors++;
        if (last_pcyc != c + 6) begin errors++; $display("FAIL bounce_latency got edge %0d want %0d", last_pcyc, c + 6); end
        sw_raw = '0;
        tick(10);
    endtask

    task automatic test_multi;
        int p0, m0, c;
        p0 = pulses;
        m0 = merrs;
        sw_raw = 10'h009;
        c = cyc;
        tick(8);
        sw_raw = '0;
        tick(10);
        vectors++;
        if (merrs - m0 != 1) begin errors++; $display("FAIL multi_count got %0d want 1", merrs - m0); end
        vectors++;
        if (last_mcyc != c + 6) begin errors++; $display("FAIL multi_latency got edge %0d want %0d", last_mcyc, c + 6); end
        vectors++;
        if (pulses - p0 != 0) begin errors++; $display("FAIL multi_tenkey got %0d pulses want 0", pulses - p0); end
        vectors++;
        if (last_mkey !== 10'h000 || last_mcode !== 4'hF) begin
            errors++;
            $display("FAIL multi_outputs got tenkey %h code %h want 000 f", last_mkey, last_mcode);
        end
    endtask

    task automatic test_release_bounce;
        int p0, c;
        p0 = pulses;
        sw_raw = 10'h001;
        c = cyc;
        tick(10);
        sw_raw = '0;
        tick(2);
        sw_raw = 10'h001;
        tick(2);
        sw_raw = '0;
        tick(12);
        vectors++;
        if (pulses - p0 != 1) begin errors++; $display("FAIL relbounce_count got %0d want 1", pulses - p0); end
        vectors++;
        if (last_code !== 4'h0 || last_pcyc != c + 6) begin
            errors++;
            $display("FAIL relbounce_pulse got code %h edge %0d want 0 %0d", last_code, last_pcyc, c + 6);
        end
        sw_raw = 10'h200;
        c = cyc;
        tick(10);
        vectors++;
        if (pulses - p0 != 2 || last_code !== 4'h9 || last_pcyc != c + 6) begin
            errors++;
            $display("FAIL repress_9 got count %0d code %h edge %0d want 2 9 %0d", pulses - p0, last_code, last_pcyc, c + 6);
        end
        sw_raw = '0;
        tick(10);
    endtask

    task automatic test_reset_debounce;
        int p0, r;
        p0 = pulses;
        sw_raw = 10'h004;
        tick(3);
        reset = 1'b1;
        tick(5);
        vectors++;
        if (pulses - p0 != 0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_deb_suppress got count %0d valid %b want 0 0", pulses - p0, key_valid);
        end
        reset = 1'b0;
        r = cyc;
        tick(12);
        vectors++;
        if (pulses - p0 != 1 || last_code !== 4'h2 || last_pcyc != r + 6) begin
            errors++;
            $display("FAIL rst_deb_repress got count %0d code %h edge %0d want 1 2 %0d", pulses - p0, last_code, last_pcyc, r + 6);
        end
        sw_raw = '0;
        tick(10);
    endtask

    task automatic test_reset_wins;
        int p0, r;
        p0 = pulses;
        sw_raw = 10'h040;
        tick(5);
        reset = 1'b1;
        tick(3);
        vectors++;
        if (pulses - p0 != 0) begin errors++; $display("FAIL rst_wins got %0d pulses want 0", pulses - p0); end
        reset = 1'b0;
        r = cyc;
        tick(12);
        vectors++;
        if (pulses - p0 != 1 || last_code !== 4'h6 || last_pcyc != r + 6) begin
            errors++;
            $display("FAIL rst_wins_repress got count %0d code %h edge %0d want 1 6 %0d", pulses - p0, last_code, last_pcyc, r + 6);
        end
        sw_raw = '0;
        tick(10);
    endtask

    task automatic test_consistency;
        vectors++;
        if (bad != 0) begin errors++; $display("FAIL valid_code_consistency got %0d violations want 0", bad); end
    endtask

    initial begin
        test_reset;
        test_single_press;
        test_held_changes;
        test_bounce;
        test_multi;
        test_release_bounce;
        test_reset_debounce;
        test_reset_wins;
        test_consistency;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
